// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if
//   Command and response channels of the ALU command sequencer.
//   master : command source (drives cmd_*, rsp_ready)
//   slave  : the sequencer  (drives cmd_ready, rsp_*)
//   cmd_valid/cmd_ready  command handshake
//   cmd_op/a/b           ALU select and operands
//   cmd_use_acc          take operand A from the accumulator (accumulator build only)
//   rsp_valid/rsp_ready  response handshake
//   rsp_result/carry/zero captured ALU outputs
`timescale 1ns/1ps
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_use_acc;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Sequential front-end for a combinational 4-bit ALU. Accepts one command
//   per handshake, drives the ALU inputs from registers, waits SETTLE_CYCLES
//   clocks, samples result/carry and returns them on the response channel.
//   Optional macro ALU_CMD_ACC_EN adds a running accumulator that captures
//   every result and can replace operand A (cmd_use_acc).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus           command/response channels (slave modport)
//   alu_a/b/sel   registered ALU operand and select outputs
//   alu_result    ALU result input, alu_carry ALU carry input
//   acc           accumulator value (tied 0 without ALU_CMD_ACC_EN)
// Parameters:
//   SETTLE_CYCLES cycles between driving ALU inputs and sampling (1..15)
`timescale 1ns/1ps
module alu_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  alu_cmd_sequencer_if.slave        bus,
  output logic [3:0]                alu_a,
  output logic [3:0]                alu_b,
  output logic [2:0]                alu_sel,
  input  logic [3:0]                alu_result,
  input  logic                      alu_carry,
  output logic [3:0]                acc
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t     state;
  logic [3:0] cnt;

  // Ready is a pure decode of the registered state, never of the inputs.
  assign bus.cmd_ready = (state == IDLE);

`ifdef ALU_CMD_ACC_EN
  logic [3:0] acc_reg;
  assign acc = acc_reg;
`else
  logic unused_use_acc;
  assign unused_use_acc = bus.cmd_use_acc;
  assign acc = 4'h0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 4'h0;
      alu_a          <= 4'h0;
      alu_b          <= 4'h0;
      alu_sel        <= 3'b000;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= 4'h0;
      bus.rsp_carry  <= 1'b0;
      bus.rsp_zero   <= 1'b0;
`ifdef ALU_CMD_ACC_EN
      acc_reg        <= 4'h0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            alu_sel <= bus.cmd_op;
            alu_b   <= bus.cmd_b;
`ifdef ALU_CMD_ACC_EN
            alu_a   <= bus.cmd_use_acc ? acc_reg : bus.cmd_a;
`else
            alu_a   <= bus.cmd_a;
`endif
            cnt     <= 4'(SETTLE_CYCLES - 1);
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          // ALU inputs have been stable SETTLE_CYCLES edges when cnt hits 0.
          if (cnt == 4'h0) begin
            bus.rsp_result <= alu_result;
            bus.rsp_carry  <= alu_carry;
            bus.rsp_zero   <= (alu_result == 4'h0);
            bus.rsp_valid  <= 1'b1;
`ifdef ALU_CMD_ACC_EN
            acc_reg        <= alu_result;
`endif
            state          <= RESP;
          end else begin
            cnt <= cnt - 4'h1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
//   Self-checking bench for alu_cmd_sequencer: a behavioural 4-bit ALU feeds
//   the DUT, and a reference model (integer arithmetic plus an accumulator
//   variable) predicts operands, response data and handshake timing.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  localparam int S = 3;
`ifdef ALU_CMD_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] alu_a, alu_b, alu_result, acc;
  logic [2:0] alu_sel;
  logic       alu_carry;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int last_accept = 0;

  logic [3:0] model_acc = 4'h0;
  logic [2:0] exp_sel;
  logic [3:0] exp_a, exp_b;
  logic [4:0] exp_rsp;

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_sel(alu_sel),
    .alu_result(alu_result),
    .alu_carry(alu_carry),
    .acc(acc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU in plain integer arithmetic; returns {carry, result}.
  function automatic logic [4:0] ref_alu(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    int ia, ib, r;
    logic c;
    ia = int'(a);
    ib = int'(b);
    c = 1'b0;
    case (op)
      3'd0: begin r = ia + ib; c = (r > 15); end
      3'd1: begin r = ia - ib; c = (ia < ib); end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = 15 - ia;
      3'd6: r = ia * 2;
      default: r = ia / 2;
    endcase
    return {c, 4'(r & 15)};
  endfunction

  always_comb {alu_carry, alu_result} = ref_alu(alu_sel, alu_a, alu_b);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_result"}, bus.rsp_result, 0);
    chk({tag, "_rsp_carry"}, bus.rsp_carry, 0);
    chk({tag, "_rsp_zero"}, bus.rsp_zero, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_sel"}, alu_sel, 0);
    chk({tag, "_acc"}, acc, 0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
  endtask

  // Drive one command and let it be accepted at the next edge.
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic use_acc);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    bus.cmd_use_acc = use_acc;
    tick();
    bus.cmd_valid = 1'b0;
    last_accept = accept_cyc;
    accept_cyc  = cyc;
    exp_sel = op;
    exp_b   = b;
    exp_a   = (use_acc && ACC_EN) ? model_acc : a;
    exp_rsp = ref_alu(op, exp_a, b);
    chk("alu_sel", alu_sel, exp_sel);
    chk("alu_a", alu_a, exp_a);
    chk("alu_b", alu_b, exp_b);
    chk("cmd_ready_busy", bus.cmd_ready, 0);
    chk("rsp_valid_accept", bus.rsp_valid, 0);
  endtask

  // Wait out the settle time, check the response, optionally stall it, then complete.
  task automatic complete(input int hold);
    bus.rsp_ready = (hold == 0);
    for (int k = 1; k <= S; k++) begin
      tick();
      if (k < S) chk("rsp_valid_early", bus.rsp_valid, 0);
    end
    if (ACC_EN) model_acc = exp_rsp[3:0];
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_result", bus.rsp_result, exp_rsp[3:0]);
    chk("rsp_carry", bus.rsp_carry, exp_rsp[4]);
    chk("rsp_zero", bus.rsp_zero, (exp_rsp[3:0] == 4'h0));
    chk("acc", acc, model_acc);
    for (int h = 0; h < hold; h++) begin
      bus.cmd_valid   = 1'b1;
      bus.cmd_op      = 3'($urandom_range(0, 7));
      bus.cmd_a       = ~exp_a;
      bus.cmd_b       = ~exp_b;
      bus.cmd_use_acc = 1'b0;
      tick();
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rsp_result", bus.rsp_result, exp_rsp[3:0]);
      chk("hold_cmd_ready", bus.cmd_ready, 0);
      chk("hold_alu_a", alu_a, exp_a);
      chk("hold_alu_sel", alu_sel, exp_sel);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("done_rsp_valid", bus.rsp_valid, 0);
    chk("done_cmd_ready", bus.cmd_ready, 1);
    chk("done_rsp_result", bus.rsp_result, exp_rsp[3:0]);
    chk("done_alu_b", alu_b, exp_b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 3'd0;
    bus.cmd_a       = 4'h0;
    bus.cmd_b       = 4'h0;
    bus.cmd_use_acc = 1'b0;
    bus.rsp_ready   = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_vals("reset");

    // Directed arithmetic corners.
    issue(3'd0, 4'h9, 4'h8, 1'b0); complete(0);   // 9+8 -> 1, carry
    issue(3'd1, 4'h3, 4'h5, 1'b0); complete(0);   // 3-5 -> E, borrow
    issue(3'd1, 4'h5, 4'h5, 1'b0); complete(0);   // 5-5 -> 0, zero
    issue(3'd4, 4'hA, 4'h5, 1'b0); complete(0);   // xor -> F
    chk("spacing_xor", 8'(accept_cyc - last_accept), 8'(S + 2));

    // Long response stall with a competing command that must be ignored.
    issue(3'd3, 4'h2, 4'h4, 1'b0); complete(10);

    // Back-to-back spacing with rsp_ready held high.
    for (int i = 0; i < 4; i++) begin
      issue(3'(i + 2), 4'(i * 3 + 1), 4'(i + 7), 1'b0);
      complete(0);
      if (i > 0) chk("spacing_b2b", 8'(accept_cyc - last_accept), 8'(S + 2));
    end

    // Accumulator chaining (alu_a stays cmd_a without the accumulator build).
    issue(3'd0, 4'h7, 4'h0, 1'b0); complete(0);
    issue(3'd0, 4'h3, 4'h6, 1'b1); complete(0);

    // Reset while settling: nothing comes back.
    issue(3'd0, 4'hF, 4'hF, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_acc = 4'h0;
    chk_reset_vals("rst_settle");
    repeat (S + 2) tick();
    chk("rst_settle_no_rsp", bus.rsp_valid, 0);
    chk("rst_settle_ready", bus.cmd_ready, 1);
    issue(3'd6, 4'h9, 4'h0, 1'b0); complete(0);

    // Reset while a response is stalled.
    issue(3'd7, 4'hB, 4'h1, 1'b0);
    bus.rsp_ready = 1'b0;
    repeat (S) tick();
    chk("rst_resp_pending", bus.rsp_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    model_acc = 4'h0;
    chk_reset_vals("rst_resp");
    repeat (S + 2) tick();
    chk("rst_resp_no_rsp", bus.rsp_valid, 0);
    issue(3'd5, 4'h6, 4'h0, 1'b0); complete(1);

    // Randomised commands with random response stalls.
    for (int i = 0; i < 24; i++) begin
      issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      complete(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
